// File: rtl/mrd_col_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mrd_col_sequencer: steps the MRD solver column by column, captures each   |
// | result column into an on-chip buffer and serves it on a read port.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mrd_col_sequencer #(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8,
   parameter int ITER_NUM  = 2,
   parameter int ITER_LAT  = 4,
   parameter int ONE_VAL   = 1,
   parameter int INIT_GAIN = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           start,
   input  logic                           abort,
   output logic [DIMENSION*WIDTH-1:0]     ej,
   output logic [DIMENSION*WIDTH-1:0]     M_init,
   output logic                           solver_en,
   input  logic [DIMENSION*WIDTH-1:0]     M_iter,
   output logic [$clog2(DIMENSION)-1:0]   col_idx,
   output logic                           col_valid,
   output logic                           busy,
   output logic                           done,
   input  logic [$clog2(DIMENSION)-1:0]   rd_addr,
   output logic [DIMENSION*WIDTH-1:0]     rd_data
);

   localparam int c_aw       = $clog2(DIMENSION);
   localparam int c_dw       = DIMENSION * WIDTH;
   localparam int c_iter_cyc = ITER_NUM * ITER_LAT;
   localparam int c_cw       = $clog2(c_iter_cyc + 1);
   localparam logic [WIDTH-1:0] c_one  = WIDTH'(ONE_VAL);
   localparam logic [WIDTH-1:0] c_init = WIDTH'(ONE_VAL * INIT_GAIN);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ITER    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t            r_state, w_state_n;
   logic [c_aw-1:0]   r_col, w_col_n;
   logic [c_cw-1:0]   r_cnt, w_cnt_n;
   logic              w_active;
   logic              w_wr;
   logic [c_dw-1:0]   r_buf [DIMENSION];
   logic [c_dw-1:0]   w_rd_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_col   <= '0;
         r_cnt   <= '0;
      end else if (en) begin
         r_state <= w_state_n;
         r_col   <= w_col_n;
         r_cnt   <= w_cnt_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_col_n   = r_col;
      w_cnt_n   = r_cnt;
      w_active  = 1'b0;
      w_wr      = 1'b0;
      solver_en = 1'b0;
      col_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      ej        = '0;
      M_init    = '0;

      case (r_state)
         S_LOAD: begin
            w_active  = 1'b1;
            busy      = 1'b1;
            w_state_n = S_ITER;
            w_cnt_n   = '0;
         end
         S_ITER: begin
            w_active  = 1'b1;
            busy      = 1'b1;
            solver_en = 1'b1;
            if (r_cnt == c_cw'(c_iter_cyc - 1)) begin
               w_state_n = S_CAPTURE;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         S_CAPTURE: begin
            w_active  = 1'b1;
            busy      = 1'b1;
            col_valid = 1'b1;
            w_wr      = 1'b1;
            if (r_col == c_aw'(DIMENSION - 1)) begin
               w_state_n = S_DONE;
               w_col_n   = '0;
            end else begin
               w_state_n = S_LOAD;
               w_col_n   = r_col + 1'b1;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            w_state_n = S_IDLE;
            w_col_n   = '0;
         end
         default: begin
            if (start) begin
               w_state_n = S_LOAD;
               w_col_n   = '0;
               w_cnt_n   = '0;
            end
         end
      endcase

      // abort wins over every transition above, including the capture write
      if (abort && r_state != S_IDLE) begin
         w_state_n = S_IDLE;
         w_col_n   = '0;
         w_cnt_n   = '0;
         w_wr      = 1'b0;
      end

      for (int k = 0; k < DIMENSION; k++) begin
         if (w_active && r_col == c_aw'(k)) begin
            ej[k*WIDTH +: WIDTH]     = c_one;
            M_init[k*WIDTH +: WIDTH] = c_init;
         end
      end
   end

   assign col_idx = r_col;

   always_ff @(posedge clk) begin
      if (en && w_wr) begin
         r_buf[r_col] <= M_iter;
      end
   end

   generate
      if ((1 << c_aw) > DIMENSION) begin : g_rd_guard
         assign w_rd_val = (int'(rd_addr) < DIMENSION) ? r_buf[rd_addr] : '0;
      end else begin : g_rd_full
         assign w_rd_val = r_buf[rd_addr];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (en) begin
         rd_data <= w_rd_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mrd_col_sequencer.sv
`default_nettype none
// Randomized bench for mrd_col_sequencer; a position-in-run model predicts
// every output each cycle, plus directed latency / abort / reset scenarios.
module tb_mrd_col_sequencer;

   localparam int DIM = 16;
   localparam int W   = 8;
   localparam int PER = 2 * 4 + 2;
   localparam int TOT = DIM * PER;
   localparam int DW  = DIM * W;
   localparam int AW  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] m_iter = '0;
   logic [AW-1:0] rd_addr = '0;

   logic [DW-1:0] ej, m_init, rd_data, ej2, m_init2, rd_data2;
   logic          solver_en, col_valid, busy, done;
   logic          solver_en2, col_valid2, busy2, done2;
   logic [AW-1:0] col_idx, col_idx2;

   mrd_col_sequencer u_dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
      .ej(ej), .M_init(m_init), .solver_en(solver_en), .M_iter(m_iter),
      .col_idx(col_idx), .col_valid(col_valid), .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_data(rd_data));

   mrd_col_sequencer #(.ONE_VAL(64), .INIT_GAIN(3)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
      .ej(ej2), .M_init(m_init2), .solver_en(solver_en2), .M_iter(m_iter),
      .col_idx(col_idx2), .col_valid(col_valid2), .busy(busy2), .done(done2),
      .rd_addr(rd_addr), .rd_data(rd_data2));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: position p within a run (1..TOT columns, TOT+1 = done)
   bit            m_run;
   int            m_p;
   logic [DW-1:0] m_buf [DIM];
   bit            m_val [DIM];
   logic [DW-1:0] m_rd;
   bit            m_rd_known;
   bit            sol3;
   int            cyc = 0;
   int            n_done = 0;
   int            last_done = -1;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] vec1(input int col, input logic [W-1:0] v);
      logic [DW-1:0] r;
      r = '0;
      if (col >= 0 && col < DIM) r[col*W +: W] = v;
      return r;
   endfunction

   function automatic bit in_col();
      return m_run && m_p >= 1 && m_p <= TOT;
   endfunction

   task automatic model_reset();
      m_run = 0;
      m_p = 0;
      m_rd = '0;
      m_rd_known = 1;
      for (int i = 0; i < DIM; i++) m_val[i] = 0;
   endtask

   task automatic model_step();
      int pos;
      if (!rst) begin
         model_reset();
         return;
      end
      if (!en) return;
      if (int'(rd_addr) >= DIM) begin
         m_rd = '0;
         m_rd_known = 1;
      end else if (m_val[rd_addr]) begin
         m_rd = m_buf[rd_addr];
         m_rd_known = 1;
      end else begin
         m_rd_known = 0;
      end
      if (m_run) begin
         if (abort) begin
            m_run = 0;
         end else begin
            pos = (m_p - 1) % PER;
            if (m_p <= TOT && pos == PER - 1) begin
               m_buf[(m_p - 1) / PER] = m_iter;
               m_val[(m_p - 1) / PER] = 1;
            end
            if (m_p == TOT + 1) m_run = 0;
            else m_p++;
         end
      end else if (start) begin
         m_run = 1;
         m_p = 1;
      end
   endtask

   task automatic check_outputs();
      bit ic;
      int col, pos;
      logic [W-1:0] g2;
      ic  = in_col();
      col = ic ? (m_p - 1) / PER : 0;
      pos = ic ? (m_p - 1) % PER : 0;
      g2  = W'(64 * 3);
      check("ej", ej, ic ? vec1(col, 8'd1) : '0);
      check("m_init", m_init, ic ? vec1(col, 8'd1) : '0);
      check("ej_p64", ej2, ic ? vec1(col, 8'd64) : '0);
      check("m_init_p64", m_init2, ic ? vec1(col, g2) : '0);
      check("solver_en", solver_en, ic && pos >= 1 && pos <= PER - 2);
      check("col_valid", col_valid, ic && pos == PER - 1);
      check("busy", busy, ic);
      check("done", done, m_run && m_p == TOT + 1);
      check("col_idx", col_idx, col);
      if (m_rd_known) check("rd_data", rd_data, m_rd);
   endtask

   task automatic drive_solver();
      if (sol3) begin
         m_iter = in_col() ? vec1((m_p - 1) / PER, 8'd3) : '0;
      end else begin
         for (int i = 0; i < DW / 32; i++) m_iter[i*32 +: 32] = $urandom();
      end
   endtask

   task automatic cycle();
      drive_solver();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check_outputs();
      if (done) begin
         n_done++;
         last_done = cyc;
      end
   endtask

   task automatic step_until(input int target);
      int g = 0;
      while (!(m_run && m_p == target) && g < 1000) begin
         cycle();
         g++;
      end
      if (g >= 1000) check("step_timeout", g, 0);
   endtask

   task automatic step_idle();
      int g = 0;
      while (m_run && g < 1000) begin
         cycle();
         g++;
      end
      if (g >= 1000) check("idle_timeout", g, 0);
   endtask

   task automatic kick(output int s0);
      start = 1'b1;
      s0 = cyc;
      last_done = -1;
      cycle();
      start = 1'b0;
   endtask

   initial begin
      int s0, nv, d0;
      logic [DW-1:0] old4, new4;

      model_reset();
      @(negedge clk);
      check_outputs();
      rst = 1'b1;
      cycle();

      // nominal run, solver returns 3*ej
      sol3 = 1;
      nv = 0;
      kick(s0);
      while (m_run) begin
         if (col_valid) nv++;
         cycle();
         if (cyc - s0 > 400) break;
      end
      check("a_latency", last_done - s0, TOT + 1);
      check("a_ncol", nv, DIM);
      rd_addr = 4'd7;
      cycle();
      check("a_rd7", rd_data, vec1(7, 8'd3));

      // en freeze for 5 cycles in ITER of column 2
      sol3 = 0;
      kick(s0);
      step_until(2 * PER + 1 + 3);
      en = 1'b0;
      repeat (5) cycle();
      en = 1'b1;
      step_idle();
      check("b_latency", last_done - s0, TOT + 1 + 5);

      // abort in CAPTURE of column 3
      d0 = n_done;
      kick(s0);
      step_until(4 * PER);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      check("c_busy", busy, 1'b0);
      repeat (3) cycle();
      check("c_nodone", n_done - d0, 0);
      for (int a = 0; a < 5; a++) begin
         rd_addr = AW'(a);
         cycle();
      end

      // start while busy; read-during-write on column 4
      kick(s0);
      step_until(25);
      start = 1'b1;
      cycle();
      start = 1'b0;
      step_until(5 * PER);
      old4 = m_buf[4];
      rd_addr = 4'd4;
      cycle();
      new4 = m_iter;
      check("d_rd_old", rd_data, old4);
      cycle();
      check("d_rd_new", rd_data, new4);
      step_idle();
      check("d_latency", last_done - s0, TOT + 1);

      // asynchronous reset mid-ITER of column 5, then full restart
      kick(s0);
      step_until(5 * PER + 1 + 4);
      #2 rst = 1'b0;
      #1;
      check("r_ej", ej, '0);
      check("r_m_init", m_init, '0);
      check("r_solver_en", solver_en, 1'b0);
      check("r_busy", busy, 1'b0);
      check("r_col_idx", col_idx, '0);
      check("r_rd_data", rd_data, '0);
      model_reset();
      @(negedge clk);
      cycle();
      rst = 1'b1;
      kick(s0);
      step_idle();
      check("e_latency", last_done - s0, TOT + 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         en      = ($urandom_range(0, 9) != 0);
         start   = ($urandom_range(0, 19) == 0);
         abort   = ($urandom_range(0, 199) == 0);
         rd_addr = AW'($urandom_range(0, DIM - 1));
         cycle();
      end
      en = 1'b1;
      start = 1'b0;
      abort = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mrd_col_sequencer.md
Name: mrd_col_sequencer

Overview:
- Drives the MRD approximate-inverse solver one column at a time. For each column j it generates the unit vector ej and the initial guess M_init.
- Runs the solver for ITER_NUM iterations, then captures the returned M_iter column into an on-chip column buffer.
- After all DIMENSION columns, the buffer holds the approximate inverse. A read port serves it to downstream consumers.

Parameters:
- DIMENSION, 16, matrix order and number of columns.
- WIDTH, 8, signed element width.
- ITER_NUM, 2, solver iterations per column (≥1).
- ITER_LAT, 4, clock cycles the solver needs per iteration (≥1).
- ONE_VAL, 1, signed fixed-point value placed at the nonzero position of ej.
- INIT_GAIN, 1, signed scale applied to ej to form M_init.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  global enable; 0 freezes all state, outputs hold.
- start  in  1  begin a full 16-column inversion; sampled only in IDLE.
- abort  in  1  terminate the current inversion.
- ej  out  DIMENSION*WIDTH  unit vector for the current column, to the solver.
- M_init  out  DIMENSION*WIDTH  initial column guess, to the solver.
- solver_en  out  1  enable to the solver during iteration.
- M_iter  in  DIMENSION*WIDTH  solver result column.
- col_idx  out  clog2(DIMENSION)  current column index, 0-based.
- col_valid  out  1  one-cycle pulse when a column is captured.
- busy  out  1  high from LOAD through CAPTURE of the last column.
- done  out  1  one-cycle pulse after the last column is captured.
- rd_addr  in  clog2(DIMENSION)  buffer column to read.
- rd_data  out  DIMENSION*WIDTH  registered buffer read data.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; col_idx=0; iteration counter=0.
  - ej=0, M_init=0, solver_en=0, col_valid=0, busy=0, done=0, rd_data=0.
  - Buffer contents are undefined after reset.
- Vector packing: element k (0-based) occupies bits [k*WIDTH +: WIDTH].
  - ej has ONE_VAL at element col_idx and 0 elsewhere.
  - M_init = ej with the nonzero element replaced by (ONE_VAL*INIT_GAIN), truncated to the low WIDTH bits as two's complement.
- en=0: no state, counter, output or buffer changes. Pulses in flight are held; they do not repeat. start/abort are ignored.
- FSM (all transitions require en=1):
  - IDLE:
    - start=1 → LOAD, col_idx=0.
    - busy=0; ej and M_init are driven to 0.
  - LOAD:
    - 1 cycle; ej and M_init present and valid; solver_en=0; busy=1.
    - → ITER, counter=0.
  - ITER:
    - solver_en=1; counter increments each cycle.
    - When counter = ITER_NUM*ITER_LAT-1 → CAPTURE.
    - ej and M_init are held stable throughout.
  - CAPTURE:
    - 1 cycle; solver_en=0; M_iter written to buffer[col_idx]; col_valid=1.
    - col_idx<DIMENSION-1: col_idx+1, → LOAD.
    - Otherwise: → DONE.
  - DONE:
    - 1 cycle; done=1; busy=0; col_idx=0.
    - → IDLE.
- Timing:
  - Per-column cycle count = ITER_NUM*ITER_LAT+2 (default 10).
  - First LOAD occurs the cycle after start is sampled.
  - done is asserted DIMENSION*(ITER_NUM*ITER_LAT+2)+1 cycles after the start edge (default 161).
- start outside IDLE: ignored, no side effect.
- abort=1 in any non-IDLE state:
  - Next state IDLE; solver_en=0; col_idx=0; done is NOT pulsed.
  - Columns already captured remain in the buffer.
  - A column whose CAPTURE coincides with abort is NOT written.
  - abort has priority over start.
- Read port:
  - rd_data <= buffer[rd_addr] on each enabled clock; 1-cycle latency; allowed in any state.
  - Read and write to the same column in the same cycle returns the old contents.
  - rd_addr ≥ DIMENSION returns 0.

Test Plan:
1. Reset mid-ITER (rst low at column 5) → all outputs 0 immediately (async), state IDLE; restart with start → col_idx=0, full run completes.
2. Defaults; start pulse; solver model returns M_iter = ej*3 → col_valid pulses every 10 cycles, 16 in total. done occurs 161 cycles after start. rd_addr=7 then returns element 7 = 3, all other elements 0.
3. ONE_VAL=64, INIT_GAIN=3 → M_init element j = 192 truncated to 8 bits = -64 (0xC0); ej element j = 64.
4. en held low for 5 cycles during ITER of column 2 → counter and outputs frozen. Column 2 is captured exactly 5 cycles later than nominal; total run is 166 cycles.
5. abort asserted in the CAPTURE cycle of column 3 → buffer[3] keeps its previous value, buffer[0..2] hold new data, no done pulse, busy=0 on the next cycle.
6. start pulsed again while busy, and rd_addr=4 read during CAPTURE of column 4 → no restart; the read returns old column 4 contents, and the next read returns the new contents.
